// File: rtl/wb_queue.sv
// rtl/wb_queue.sv - register writeback queue merging ALU and load results with forwarding lookup
module wb_queue #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             alu_valid,
   input  logic [2:0]       alu_addr,
   input  logic [WIDTH-1:0] alu_data,
   output logic             alu_ready,
   input  logic             mem_valid,
   input  logic [2:0]       mem_addr,
   input  logic [WIDTH-1:0] mem_data,
   output logic             mem_ready,
   output logic             write_enable,
   output logic [2:0]       write_addr,
   output logic [WIDTH-1:0] write_data,
   input  logic [2:0]       fwd_addr,
   output logic             fwd_hit,
   output logic [WIDTH-1:0] fwd_data,
   output logic [3:0]       count,
   output logic             full,
   output logic             empty
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [2:0]       addr_q [DEPTH];
   logic [WIDTH-1:0] data_q [DEPTH];
   logic [DEPTH-1:0] valid_q;
   logic [PW-1:0]    head;
   logic [PW-1:0]    tail;
   logic [3:0]       count_q;

   logic             push_mem;
   logic             push_alu;
   logic             push;
   logic             pop;
   logic [2:0]       push_addr;
   logic [WIDTH-1:0] push_data;
   logic [PW-1:0]    fwd_idx;

   // Occupancy flags and handshakes use the current count, so a full queue refuses even while popping.
   assign count     = count_q;
   assign full      = (count_q == 4'(DEPTH));
   assign empty     = (count_q == 4'd0);
   assign mem_ready = !full;
   assign alu_ready = !full && !mem_valid;
   assign push_mem  = mem_valid && mem_ready;
   assign push_alu  = alu_valid && alu_ready;
   assign push      = push_mem || push_alu;
   assign pop       = !empty;

   // Select the accepted source; load results win over ALU results.
   always_comb begin
      push_addr = alu_addr;
      push_data = alu_data;
      if (push_mem) begin
         push_addr = mem_addr;
         push_data = mem_data;
      end
   end

   // Head entry drives the register-file port whenever anything is pending.
   always_comb begin
      write_enable = 1'b0;
      write_addr   = 3'd0;
      write_data   = '0;
      if (!empty) begin
         write_enable = 1'b1;
         write_addr   = addr_q[head];
         write_data   = data_q[head];
      end
   end

   // Walk oldest to youngest so the last match seen is the newest pending value.
   always_comb begin
      fwd_hit  = 1'b0;
      fwd_data = '0;
      fwd_idx  = head;
      for (int i = 0; i < DEPTH; i++) begin
         fwd_idx = head + PW'(i);
         if (valid_q[fwd_idx] && (addr_q[fwd_idx] == fwd_addr)) begin
            fwd_hit  = 1'b1;
            fwd_data = data_q[fwd_idx];
         end
      end
   end

   // Pointer, occupancy and storage update; reset discards everything including a same-cycle offer.
   always_ff @(posedge clk) begin
      if (rst) begin
         head    <= '0;
         tail    <= '0;
         count_q <= 4'd0;
         valid_q <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            addr_q[i] <= 3'd0;
            data_q[i] <= '0;
         end
      end else begin
         if (pop) begin
            valid_q[head] <= 1'b0;
            head          <= head + PW'(1);
         end
         if (push) begin
            addr_q[tail]  <= push_addr;
            data_q[tail]  <= push_data;
            valid_q[tail] <= 1'b1;
            tail          <= tail + PW'(1);
         end
         count_q <= count_q + {3'd0, push} - {3'd0, pop};
      end
   end

endmodule

// File: tb/tb_wb_queue.sv
// tb/tb_wb_queue.sv - self-checking bench for wb_queue against a queue-based model
module tb_wb_queue;

   localparam int DEPTH = 4;
   localparam int WIDTH = 16;

   logic             clk;
   logic             rst;
   logic             alu_valid;
   logic [2:0]       alu_addr;
   logic [WIDTH-1:0] alu_data;
   logic             alu_ready;
   logic             mem_valid;
   logic [2:0]       mem_addr;
   logic [WIDTH-1:0] mem_data;
   logic             mem_ready;
   logic             write_enable;
   logic [2:0]       write_addr;
   logic [WIDTH-1:0] write_data;
   logic [2:0]       fwd_addr;
   logic             fwd_hit;
   logic [WIDTH-1:0] fwd_data;
   logic [3:0]       count;
   logic             full;
   logic             empty;

   int n_tests;
   int n_fail;

   typedef struct packed {
      logic [2:0]       addr;
      logic [WIDTH-1:0] data;
   } entry_t;

   entry_t q[$];

   logic             e_we;
   logic [2:0]       e_wa;
   logic [WIDTH-1:0] e_wd;
   logic             e_hit;
   logic [WIDTH-1:0] e_fd;
   logic [3:0]       e_cnt;
   logic             e_mr;
   logic             e_ar;

   wb_queue #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
      .clk(clk), .rst(rst),
      .alu_valid(alu_valid), .alu_addr(alu_addr), .alu_data(alu_data), .alu_ready(alu_ready),
      .mem_valid(mem_valid), .mem_addr(mem_addr), .mem_data(mem_data), .mem_ready(mem_ready),
      .write_enable(write_enable), .write_addr(write_addr), .write_data(write_data),
      .fwd_addr(fwd_addr), .fwd_hit(fwd_hit), .fwd_data(fwd_data),
      .count(count), .full(full), .empty(empty)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Expected combinational outputs from the model queue and current inputs.
   task automatic model_outputs();
      e_cnt = 4'(q.size());
      e_we  = (q.size() > 0);
      e_wa  = (q.size() > 0) ? q[0].addr : 3'd0;
      e_wd  = (q.size() > 0) ? q[0].data : '0;
      e_hit = 1'b0;
      e_fd  = '0;
      foreach (q[i]) begin
         if (q[i].addr == fwd_addr) begin
            e_hit = 1'b1;
            e_fd  = q[i].data;
         end
      end
      e_mr = (q.size() < DEPTH);
      e_ar = (q.size() < DEPTH) && !mem_valid;
   endtask

   // Advance one clock; the model applies reset, pop and accept with pre-edge state and inputs.
   task automatic tick();
      bit acc_m;
      bit acc_a;
      entry_t em;
      entry_t ea;
      acc_m = mem_valid && (q.size() < DEPTH);
      acc_a = alu_valid && !mem_valid && (q.size() < DEPTH);
      em.addr = mem_addr; em.data = mem_data;
      ea.addr = alu_addr; ea.data = alu_data;
      @(posedge clk);
      if (rst) begin
         q.delete();
      end else begin
         if (q.size() > 0) void'(q.pop_front());
         if (acc_m) q.push_back(em);
         else if (acc_a) q.push_back(ea);
      end
      @(negedge clk);
   endtask

   task automatic idle_inputs();
      rst = 1'b0; alu_valid = 1'b0; mem_valid = 1'b0;
      alu_addr = 3'd0; alu_data = '0; mem_addr = 3'd0; mem_data = '0; fwd_addr = 3'd0;
   endtask

   task automatic test_reset();
      idle_inputs();
      rst = 1'b1; alu_valid = 1'b1; alu_addr = 3'd4; alu_data = 16'hBEEF;
      #1;
      tick();
      #1;
      n_tests++;
      if ({write_enable, write_addr, write_data, fwd_hit, fwd_data} !== {1'b0, 3'd0, 16'd0, 1'b0, 16'd0}) begin
         n_fail++;
         $display("FAIL reset_outputs: got we=%b wa=%0d wd=%h hit=%b fd=%h expected all zero",
                  write_enable, write_addr, write_data, fwd_hit, fwd_data);
      end
      n_tests++;
      if ({count, empty, full, mem_ready, alu_ready} !== {4'd0, 1'b1, 1'b0, 1'b1, 1'b1}) begin
         n_fail++;
         $display("FAIL reset_flags: got cnt=%0d e=%b f=%b mr=%b ar=%b expected 0 1 0 1 1",
                  count, empty, full, mem_ready, alu_ready);
      end
      rst = 1'b0; alu_valid = 1'b0;
      #1;
      tick();
      #1;
      n_tests++;
      if (write_enable !== 1'b0 || count !== 4'd0) begin
         n_fail++;
         $display("FAIL reset_offer_dropped: got we=%b cnt=%0d expected we=0 cnt=0", write_enable, count);
      end
   endtask

   task automatic test_alu_latency();
      idle_inputs();
      alu_valid = 1'b1; alu_addr = 3'd3; alu_data = 16'h1234;
      #1;
      tick();
      alu_valid = 1'b0;
      #1;
      n_tests++;
      if ({write_enable, write_addr, write_data} !== {1'b1, 3'd3, 16'h1234}) begin
         n_fail++;
         $display("FAIL alu_latency: got we=%b wa=%0d wd=%h expected 1 3 1234", write_enable, write_addr, write_data);
      end
      tick();
      #1;
      n_tests++;
      if (write_enable !== 1'b0 || empty !== 1'b1) begin
         n_fail++;
         $display("FAIL alu_drained: got we=%b empty=%b expected 0 1", write_enable, empty);
      end
   endtask

   task automatic test_priority();
      idle_inputs();
      alu_valid = 1'b1; alu_addr = 3'd1; alu_data = 16'h00AA;
      mem_valid = 1'b1; mem_addr = 3'd2; mem_data = 16'h00BB;
      #1;
      n_tests++;
      if (mem_ready !== 1'b1 || alu_ready !== 1'b0) begin
         n_fail++;
         $display("FAIL prio_ready: got mr=%b ar=%b expected 1 0", mem_ready, alu_ready);
      end
      tick();
      mem_valid = 1'b0;
      #1;
      n_tests++;
      if ({write_enable, write_addr, write_data} !== {1'b1, 3'd2, 16'h00BB}) begin
         n_fail++;
         $display("FAIL prio_mem_first: got we=%b wa=%0d wd=%h expected 1 2 00bb", write_enable, write_addr, write_data);
      end
      tick();
      alu_valid = 1'b0;
      #1;
      n_tests++;
      if ({write_enable, write_addr, write_data} !== {1'b1, 3'd1, 16'h00AA}) begin
         n_fail++;
         $display("FAIL prio_alu_second: got we=%b wa=%0d wd=%h expected 1 1 00aa", write_enable, write_addr, write_data);
      end
      tick();
   endtask

   task automatic test_back_to_back();
      logic [WIDTH-1:0] sent [5];
      logic [2:0]       got_a [$];
      logic [WIDTH-1:0] got_d [$];
      bit               over;
      idle_inputs();
      over = 1'b0;
      for (int k = 0; k < 5; k++) sent[k] = 16'(k * 16'h1111 + 16'h0101);
      for (int k = 0; k < 7; k++) begin
         mem_valid = (k < 5);
         mem_addr  = (k < 5) ? 3'(k + 1) : 3'd0;
         mem_data  = (k < 5) ? sent[k] : '0;
         alu_valid = 1'b1; alu_addr = 3'd7; alu_data = 16'hDEAD;
         if (k >= 5) alu_valid = 1'b0;
         #1;
         if (count > 4'(DEPTH)) over = 1'b1;
         if (write_enable) begin
            got_a.push_back(write_addr);
            got_d.push_back(write_data);
         end
         tick();
      end
      n_tests++;
      if (over) begin
         n_fail++;
         $display("FAIL b2b_count_bound: got count above %0d expected at most %0d", DEPTH, DEPTH);
      end
      n_tests++;
      if (got_a.size() != 5) begin
         n_fail++;
         $display("FAIL b2b_write_count: got %0d writes expected 5", got_a.size());
      end else begin
         for (int k = 0; k < 5; k++) begin
            n_tests++;
            if (got_a[k] !== 3'(k + 1) || got_d[k] !== sent[k]) begin
               n_fail++;
               $display("FAIL b2b_order[%0d]: got r%0d=%h expected r%0d=%h", k, got_a[k], got_d[k], k + 1, sent[k]);
            end
         end
      end
   endtask

   task automatic test_forward();
      idle_inputs();
      alu_valid = 1'b1; alu_addr = 3'd5; alu_data = 16'h0001;
      fwd_addr = 3'd5;
      #1;
      n_tests++;
      if (fwd_hit !== 1'b0 || fwd_data !== 16'd0) begin
         n_fail++;
         $display("FAIL fwd_excludes_offer: got hit=%b data=%h expected 0 0000", fwd_hit, fwd_data);
      end
      tick();
      alu_data = 16'h0002;
      #1;
      n_tests++;
      if (fwd_hit !== 1'b1 || fwd_data !== 16'h0001) begin
         n_fail++;
         $display("FAIL fwd_first: got hit=%b data=%h expected 1 0001", fwd_hit, fwd_data);
      end
      tick();
      alu_valid = 1'b0;
      #1;
      n_tests++;
      if (fwd_hit !== 1'b1 || fwd_data !== 16'h0002) begin
         n_fail++;
         $display("FAIL fwd_newest: got hit=%b data=%h expected 1 0002", fwd_hit, fwd_data);
      end
      fwd_addr = 3'd6;
      #1;
      n_tests++;
      if (fwd_hit !== 1'b0 || fwd_data !== 16'd0) begin
         n_fail++;
         $display("FAIL fwd_miss: got hit=%b data=%h expected 0 0000", fwd_hit, fwd_data);
      end
      tick();
   endtask

   task automatic test_reset_drop();
      int late_writes;
      idle_inputs();
      mem_valid = 1'b1; mem_addr = 3'd0; mem_data = 16'h5A5A;
      #1;
      tick();
      mem_valid = 1'b0;
      rst = 1'b1;
      #1;
      tick();
      rst = 1'b0;
      #1;
      n_tests++;
      if (count !== 4'd0 || write_enable !== 1'b0) begin
         n_fail++;
         $display("FAIL rst_drop: got cnt=%0d we=%b expected 0 0", count, write_enable);
      end
      late_writes = 0;
      for (int k = 0; k < 4; k++) begin
         tick();
         #1;
         if (write_enable) late_writes++;
      end
      n_tests++;
      if (late_writes != 0) begin
         n_fail++;
         $display("FAIL rst_no_ghost: got %0d writes expected 0", late_writes);
      end
   endtask

   task automatic test_random();
      int errs;
      idle_inputs();
      errs = 0;
      for (int k = 0; k < 400; k++) begin
         rst       = ($urandom_range(0, 39) == 0);
         alu_valid = $urandom_range(0, 1);
         mem_valid = ($urandom_range(0, 2) == 0);
         alu_addr  = 3'($urandom);
         mem_addr  = 3'($urandom);
         alu_data  = 16'($urandom);
         mem_data  = 16'($urandom);
         fwd_addr  = 3'($urandom);
         #1;
         model_outputs();
         n_tests++;
         if ({write_enable, write_addr, write_data, fwd_hit, fwd_data, count, mem_ready, alu_ready,
              full, empty} !==
             {e_we, e_wa, e_wd, e_hit, e_fd, e_cnt, e_mr, e_ar, (e_cnt == 4'(DEPTH)), (e_cnt == 4'd0)}) begin
            n_fail++;
            errs++;
            if (errs < 10)
               $display("FAIL random[%0d]: got we=%b wa=%0d wd=%h hit=%b fd=%h cnt=%0d mr=%b ar=%b expected we=%b wa=%0d wd=%h hit=%b fd=%h cnt=%0d mr=%b ar=%b",
                        k, write_enable, write_addr, write_data, fwd_hit, fwd_data, count, mem_ready, alu_ready,
                        e_we, e_wa, e_wd, e_hit, e_fd, e_cnt, e_mr, e_ar);
         end
         tick();
      end
      idle_inputs();
   endtask

   initial begin
      n_tests = 0;
      n_fail  = 0;
      idle_inputs();
      rst = 1'b1;
      @(negedge clk);
      @(negedge clk);
      q.delete();
      test_reset();
      test_alu_latency();
      test_priority();
      test_back_to_back();
      test_forward();
      test_reset_drop();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
